// File: rtl/aq_gemac_rx_buff.sv
`default_nettype none
// ==== aq_gemac_rx_buff : GEMAC receive packet buffer, MAC bytes in, length-headed 32-bit packets out
// ==== Rev 1.0
module aq_gemac_rx_buff #(
   parameter int EMAC_RX_DEPTH = 10
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mac_we_i,
   input  logic        mac_start_i,
   input  logic        mac_end_i,
   input  logic        mac_error_i,
   input  logic [7:0]  mac_data_i,
   output logic        buff_ready_o,
   output logic [15:0] buff_length_o,
   input  logic        buff_re_i,
   output logic        buff_valid_o,
   output logic [31:0] buff_data_o,
   output logic        buff_eop_o,
   output logic [15:0] drop_count_o
);
   localparam int AW = EMAC_RX_DEPTH;
   localparam int PW = EMAC_RX_DEPTH + 1;
   localparam logic [AW-1:0] A_ONE = {{(AW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_HEADER, W_DROP} wstate_e;
   typedef enum logic [1:0] {R_IDLE, R_HDR, R_LOAD, R_DATA} rstate_e;

   logic [31:0]   mem_q [0:(1<<AW)-1];
   wstate_e       w_state_q, w_state_d;
   logic [AW-1:0] wr_start_q, wr_start_d, wr_addr_q, wr_addr_d, wr_commit_q, wr_commit_d;
   logic [15:0]   cnt_q, cnt_d, drop_q, drop_d;
   logic [31:0]   word_q, word_d;
   rstate_e       r_state_q, r_state_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [15:0]   len_q, len_d, rem_q, rem_d;
   logic          ready_q, ready_d, valid_q, valid_d, eop_q, eop_d;
   logic [31:0]   rd_data_q;
   logic [PW-1:0] pkt_cnt_q;

   logic          mem_we, rd_en, pkt_inc, pkt_dec, drop_inc, end_frame;
   logic [AW-1:0] mem_waddr, fill_addr;
   logic [31:0]   mem_wdata, word_fill;
   logic [1:0]    lane;
   logic          overflow, hdr_full;

   // Incoming byte merged into the word under assembly; a new frame always starts from a zeroed word.
   always_comb begin
      lane      = (w_state_q == W_IDLE) ? 2'd0 : cnt_q[1:0];
      word_fill = (w_state_q == W_IDLE) ? 32'd0 : word_q;
      word_fill[{lane, 3'b000} +: 8] = mac_data_i;
      fill_addr = (w_state_q == W_IDLE) ? (wr_commit_q + A_ONE) : wr_addr_q;
      overflow  = (fill_addr + A_ONE) == rd_addr_q;
      hdr_full  = (wr_commit_q + A_ONE) == rd_addr_q;
   end

   always_comb begin
      w_state_d   = w_state_q;
      wr_start_d  = wr_start_q;
      wr_addr_d   = wr_addr_q;
      wr_commit_d = wr_commit_q;
      cnt_d       = cnt_q;
      word_d      = word_q;
      drop_d      = drop_q;
      mem_we      = 1'b0;
      mem_waddr   = fill_addr;
      mem_wdata   = word_fill;
      pkt_inc     = 1'b0;
      drop_inc    = 1'b0;
      end_frame   = 1'b0;
      case (w_state_q)
         W_IDLE: if (mac_we_i && mac_start_i) begin
            wr_start_d = wr_commit_q;
            cnt_d      = 16'd1;
            word_d     = word_fill;
            if (hdr_full) begin
               wr_addr_d = wr_commit_q;
               if (mac_end_i) drop_inc = 1'b1;
               else           w_state_d = W_DROP;
            end else begin
               wr_addr_d = fill_addr;
               w_state_d = W_DATA;
               end_frame = mac_end_i;
            end
         end
         W_DATA: if (mac_we_i) begin
            cnt_d  = cnt_q + 16'd1;
            word_d = word_fill;
            if (mac_end_i) begin
               end_frame = 1'b1;
            end else if (lane == 2'd3) begin
               if (overflow) begin
                  w_state_d = W_DROP;
               end else begin
                  mem_we    = 1'b1;
                  wr_addr_d = wr_addr_q + A_ONE;
                  word_d    = 32'd0;
               end
            end
         end
         W_HEADER: begin
            mem_we      = 1'b1;
            mem_waddr   = wr_start_q;
            mem_wdata   = {16'd0, cnt_q};
            wr_commit_d = wr_addr_q;
            pkt_inc     = 1'b1;
            w_state_d   = W_IDLE;
         end
         W_DROP: if (mac_we_i && mac_end_i) begin
            drop_inc  = 1'b1;
            wr_addr_d = wr_commit_q;
            w_state_d = W_IDLE;
         end
      endcase
      // Frame end: errors and a full ring rewind; otherwise flush the (possibly partial) word.
      if (end_frame) begin
         if (mac_error_i || overflow) begin
            drop_inc  = 1'b1;
            wr_addr_d = wr_commit_q;
            w_state_d = W_IDLE;
         end else begin
            mem_we    = 1'b1;
            wr_addr_d = fill_addr + A_ONE;
            w_state_d = W_HEADER;
         end
         word_d = 32'd0;
      end
      if (drop_inc && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
   end

   always_comb begin
      r_state_d = r_state_q;
      rd_addr_d = rd_addr_q;
      len_d     = len_q;
      rem_d     = rem_q;
      ready_d   = ready_q;
      valid_d   = 1'b0;
      eop_d     = 1'b0;
      rd_en     = 1'b0;
      pkt_dec   = 1'b0;
      case (r_state_q)
         R_IDLE: if (pkt_cnt_q != '0) begin
            rd_en     = 1'b1;
            r_state_d = R_HDR;
         end
         R_HDR: r_state_d = R_LOAD;
         R_LOAD: begin
            len_d     = rd_data_q[15:0];
            rem_d     = {2'b00, rd_data_q[15:2]} + {15'd0, |rd_data_q[1:0]};
            rd_addr_d = rd_addr_q + A_ONE;
            ready_d   = 1'b1;
            r_state_d = R_DATA;
         end
         R_DATA: if (buff_re_i && rem_q != 16'd0) begin
            rd_en     = 1'b1;
            rd_addr_d = rd_addr_q + A_ONE;
            rem_d     = rem_q - 16'd1;
            valid_d   = 1'b1;
            eop_d     = (rem_q == 16'd1);
            if (rem_q == 16'd1) begin
               ready_d   = 1'b0;
               pkt_dec   = 1'b1;
               r_state_d = R_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         w_state_q   <= W_IDLE;
         wr_start_q  <= '0;
         wr_addr_q   <= '0;
         wr_commit_q <= '0;
         cnt_q       <= 16'd0;
         word_q      <= 32'd0;
         drop_q      <= 16'd0;
         r_state_q   <= R_IDLE;
         rd_addr_q   <= '0;
         len_q       <= 16'd0;
         rem_q       <= 16'd0;
         ready_q     <= 1'b0;
         valid_q     <= 1'b0;
         eop_q       <= 1'b0;
         rd_data_q   <= 32'd0;
         pkt_cnt_q   <= '0;
      end else begin
         w_state_q   <= w_state_d;
         wr_start_q  <= wr_start_d;
         wr_addr_q   <= wr_addr_d;
         wr_commit_q <= wr_commit_d;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         drop_q      <= drop_d;
         r_state_q   <= r_state_d;
         rd_addr_q   <= rd_addr_d;
         len_q       <= len_d;
         rem_q       <= rem_d;
         ready_q     <= ready_d;
         valid_q     <= valid_d;
         eop_q       <= eop_d;
         if (rd_en) rd_data_q <= mem_q[rd_addr_q];
         pkt_cnt_q   <= pkt_cnt_q + {{(PW-1){1'b0}}, pkt_inc} - {{(PW-1){1'b0}}, pkt_dec};
      end
   end

   assign buff_ready_o  = ready_q;
   assign buff_length_o = len_q;
   assign buff_valid_o  = valid_q;
   assign buff_data_o   = rd_data_q;
   assign buff_eop_o    = eop_q;
   assign drop_count_o  = drop_q;

endmodule
`default_nettype wire
